axi_sampler_fifo_mc: RTL and testbench

- Multi-channel successor of the single-channel AXI sampler-with-FIFO block.
- Snapshots NUM_CH input channels on a programmable sample tick and serialises the enabled channels into a tagged FIFO.
- The CPU reads the FIFO through a simple register port.
- Integrated interrupt controller uses the existing map: GIE 0x00, IER 0x04, IAR 0x0C, IPR 0x10. Sits behind the AXI-Lite bridge in the block design.

---
 rtl/axi_sampler_fifo_mc.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_sampler_fifo_mc.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/axi_sampler_fifo_mc.sv
// Multi-channel sampler: snapshots NUM_CH inputs on a divider tick and pushes the enabled
// channels, tagged with their index, into a FIFO read through a small register port with IRQ logic.
module axi_sampler_fifo_mc #(
  parameter int NUM_CH           = 4,
  parameter int SAMPLE_W         = 16,
  parameter int FIFO_DEPTH       = 16,
  parameter int DIV_W            = 16,
  parameter bit IRQ_ACTIVE_STATE = 1'b1
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
  input  logic [7:0]                 reg_addr,
  input  logic                       reg_wr,
  input  logic [31:0]                reg_wdata,
  input  logic                       reg_rd,
  output logic [31:0]                reg_rdata,
  output logic                       reg_rvalid,
  output logic                       irq
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, SCAN} state_e;

  state_e                          state_q, state_d;
  logic                            gie_q, gie_d, en_q, en_d, oneshot_q, oneshot_d;
  logic                            flush_q, flush_d, raw0_q, raw0_d, irq_q, irq_d, rvalid_q;
  logic [3:0]                      ier_q, ier_d, ipr_q, ipr_d;
  logic [NUM_CH-1:0]               mask_q, mask_d, pend_q, pend_d, pend_clr;
  logic [NUM_CH-1:0][SAMPLE_W-1:0] snap_q, snap_d;
  logic [DIV_W-1:0]                div_q, div_d, div_cnt_q, div_cnt_d;
  logic [31:0]                     thresh_q, thresh_d, count_q, count_d, scan_cnt_q, scan_cnt_d;
  logic [PW-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]                   level_q, level_d;
  logic [31:0]                     rdata_q, rdata_d;
  logic [31:0]                     mem_q [FIFO_DEPTH];

  logic                tick, push, push_ok, pop, full, ovf, done, missed, thr;
  logic [3:0]          raw, iar_clr;
  logic [7:0]          cur_idx;
  logic [SAMPLE_W-1:0] cur_smp;
  logic [31:0]         push_data, head;
  logic [5:0]          word;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^reg_addr[1:0];

  always_comb begin
    word       = reg_addr[7:2];
    gie_d      = gie_q;
    ier_d      = ier_q;
    en_d       = en_q;
    oneshot_d  = oneshot_q;
    flush_d    = 1'b0;
    mask_d     = mask_q;
    div_d      = div_q;
    thresh_d   = thresh_q;
    count_d    = count_q;
    state_d    = state_q;
    pend_d     = pend_q;
    snap_d     = snap_q;
    scan_cnt_d = scan_cnt_q;
    push       = 1'b0;
    done       = 1'b0;
    missed     = 1'b0;
    iar_clr    = '0;
    tick       = (state_q != IDLE) && (div_cnt_q == div_q);
    div_cnt_d  = div_cnt_q;
    if (state_q != IDLE) div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);

    // Lowest pending channel is the one pushed this cycle; x & (x-1) retires it.
    cur_idx = '0;
    cur_smp = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (pend_q[c]) begin
        cur_idx = 8'(c);
        cur_smp = snap_q[c];
      end
    pend_clr  = pend_q & (pend_q - NUM_CH'(1));
    push_data = {8'h00, cur_idx, 16'(cur_smp)};

    case (state_q)
      RUN: if (tick) begin
        if (mask_q == '0) scan_cnt_d = scan_cnt_q + 32'd1;
        else begin
          snap_d  = sample_in;
          pend_d  = mask_q;
          state_d = SCAN;
        end
      end
      SCAN: begin
        missed = tick;
        push   = 1'b1;
        pend_d = pend_clr;
        if (pend_clr == '0) begin
          scan_cnt_d = scan_cnt_q + 32'd1;
          if (oneshot_q && (scan_cnt_d == count_q)) begin
            en_d    = 1'b0;
            done    = 1'b1;
            state_d = IDLE;
          end else state_d = RUN;
        end
      end
      default: ;
    endcase

    if (reg_wr) begin
      case (word)
        6'h00: gie_d = reg_wdata[0];
        6'h01: ier_d = reg_wdata[3:0];
        6'h03: iar_clr = reg_wdata[3:0];
        6'h05: begin
          en_d      = reg_wdata[0];
          oneshot_d = reg_wdata[1];
          flush_d   = reg_wdata[2];
          mask_d    = reg_wdata[16 +: NUM_CH];
          if (reg_wdata[0] && (!en_q || done)) begin
            state_d    = RUN;
            div_cnt_d  = '0;
            scan_cnt_d = '0;
          end else if (!reg_wdata[0]) begin
            // Abort: the in-flight channel is dropped and the partial scan is not counted.
            state_d    = IDLE;
            push       = 1'b0;
            done       = 1'b0;
            scan_cnt_d = scan_cnt_q;
          end
        end
        6'h06: div_d    = reg_wdata[DIV_W-1:0];
        6'h07: thresh_d = reg_wdata;
        6'h08: count_d  = reg_wdata;
        default: ;
      endcase
    end

    full     = (level_q == LW'(FIFO_DEPTH));
    pop      = reg_rd && (word == 6'h0A) && (level_q != '0);
    push_ok  = push && !flush_q && (!full || pop);
    ovf      = push && !flush_q && full && !pop;
    head     = mem_q[rd_ptr_q];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop);
    end

    thr    = (thresh_q != '0) && (32'(level_q) >= thresh_q);
    raw    = {missed, done, ovf, thr};
    raw0_d = thr;
    ipr_d  = (ipr_q & ~iar_clr) | (ier_q & {raw[3:1], thr & ~raw0_q});
    irq_d  = (gie_q && (ipr_q != '0)) ? IRQ_ACTIVE_STATE : ~IRQ_ACTIVE_STATE;

    rdata_d = '0;
    if (reg_rd) begin
      case (word)
        6'h00: rdata_d = {31'b0, gie_q};
        6'h01: rdata_d = {28'b0, ier_q};
        6'h02: rdata_d = {28'b0, raw};
        6'h04: rdata_d = {28'b0, ipr_q};
        6'h05: rdata_d = (32'(mask_q) << 16) | {30'b0, oneshot_q, en_q};
        6'h06: rdata_d = 32'(div_q);
        6'h07: rdata_d = thresh_q;
        6'h08: rdata_d = count_q;
        6'h09: rdata_d = 32'(level_q);
        6'h0A: rdata_d = pop ? head : 32'h0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= IDLE;
      gie_q      <= 1'b0;
      ier_q      <= '0;
      ipr_q      <= '0;
      en_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      flush_q    <= 1'b0;
      mask_q     <= '0;
      div_q      <= '0;
      thresh_q   <= '0;
      count_q    <= '0;
      scan_cnt_q <= '0;
      div_cnt_q  <= '0;
      pend_q     <= '0;
      snap_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      raw0_q     <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= ~IRQ_ACTIVE_STATE;
    end else begin
      state_q    <= state_d;
      gie_q      <= gie_d;
      ier_q      <= ier_d;
      ipr_q      <= ipr_d;
      en_q       <= en_d;
      oneshot_q  <= oneshot_d;
      flush_q    <= flush_d;
      mask_q     <= mask_d;
      div_q      <= div_d;
      thresh_q   <= thresh_d;
      count_q    <= count_d;
      scan_cnt_q <= scan_cnt_d;
      div_cnt_q  <= div_cnt_d;
      pend_q     <= pend_d;
      snap_q     <= snap_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      raw0_q     <= raw0_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= reg_rd;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge ACLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign irq        = irq_q;
endmodule

// File: tb/tb_axi_sampler_fifo_mc.sv
// Directed bench for axi_sampler_fifo_mc: register map, tick/scan timing, FIFO limits,
// interrupt edge/clear behaviour, mid-scan abort and asynchronous reset.
module tb_axi_sampler_fifo_mc;
  localparam int NUM_CH = 4, SAMPLE_W = 16, FIFO_DEPTH = 16, DIV_W = 16;
  localparam bit IRQ_ACT = 1'b1;
  localparam logic [31:0] IRQ_ON  = {31'b0, IRQ_ACT};
  localparam logic [31:0] IRQ_OFF = {31'b0, ~IRQ_ACT};

  logic                       ACLK = 1'b0;
  logic                       ARESET = 1'b1;
  logic [NUM_CH*SAMPLE_W-1:0] sample_in;
  logic [7:0]                 reg_addr;
  logic                       reg_wr, reg_rd, reg_rvalid, irq;
  logic [31:0]                reg_wdata, reg_rdata;
  int                         n_chk = 0;
  int                         n_fail = 0;

  axi_sampler_fifo_mc #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W(DIV_W), .IRQ_ACTIVE_STATE(IRQ_ACT)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .sample_in(sample_in),
    .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata), .reg_rvalid(reg_rvalid), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] v);
    reg_addr = a; reg_wdata = v; reg_wr = 1'b1;
    cyc(1);
    reg_wr = 1'b0;
  endtask

  task automatic rchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    reg_addr = a; reg_rd = 1'b1;
    cyc(1);
    reg_rd = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, reg_rvalid}, 32'h1);
    chk(tag, reg_rdata, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sample_in = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    reg_addr = '0; reg_wdata = '0; reg_wr = 1'b0; reg_rd = 1'b0;

    // Reset state and register map
    cyc(3);
    chk("irq_in_reset", {31'b0, irq}, IRQ_OFF);
    chk("rvalid_in_reset", {31'b0, reg_rvalid}, 32'h0);
    ARESET = 1'b0;
    cyc(1);
    for (int a = 0; a <= 'h28; a += 4) begin
      rchk($sformatf("rst_rd_%02h", a), 8'(a), 32'h0);
      cyc(1);
      chk("rvalid_one_cycle", {31'b0, reg_rvalid}, 32'h0);
    end
    chk("irq_after_reset", {31'b0, irq}, IRQ_OFF);

    // DIV=9, mask 0b1011: first tick 10 cycles after EN, pushes on 3 consecutive cycles
    wr(8'h18, 32'd9);
    wr(8'h14, 32'h000B_0001);
    cyc(10);
    for (int i = 0; i < 4; i++) rchk($sformatf("t2_level_%0d", i), 8'h24, 32'(i));
    wr(8'h14, 32'h0);
    rchk("t2_data0", 8'h28, 32'h0000_0011);
    rchk("t2_data1", 8'h28, 32'h0001_0022);
    rchk("t2_data2", 8'h28, 32'h0003_0044);
    rchk("t2_level_end", 8'h24, 32'h0);

    // One-shot single scan, DONE interrupt, IAR clear and irq lag
    wr(8'h00, 32'h1); wr(8'h04, 32'h4); wr(8'h18, 32'd2); wr(8'h20, 32'd1);
    wr(8'h14, 32'h000F_0003);
    cyc(12);
    rchk("t3_level", 8'h24, 32'd4);
    rchk("t3_ctrl", 8'h14, 32'h000F_0002);
    rchk("t3_ipr", 8'h10, 32'h4);
    chk("t3_irq_on", {31'b0, irq}, IRQ_ON);
    wr(8'h0C, 32'h4);
    chk("t3_irq_lag", {31'b0, irq}, IRQ_ON);
    cyc(1);
    chk("t3_irq_off", {31'b0, irq}, IRQ_OFF);
    rchk("t3_ipr_clr", 8'h10, 32'h0);
    wr(8'h14, 32'h4);
    cyc(1);
    rchk("t3_flush", 8'h24, 32'h0);

    // Five scans of 4 into a 16-deep FIFO: full, overflow, drain, empty read
    wr(8'h04, 32'h2); wr(8'h18, 32'd5); wr(8'h20, 32'd5);
    wr(8'h14, 32'h000F_0003);
    cyc(45);
    rchk("t4_level_full", 8'h24, 32'd16);
    rchk("t4_ipr_ovf", 8'h10, 32'h2);
    rchk("t4_ctrl_done", 8'h14, 32'h000F_0002);
    wr(8'h0C, 32'hF);
    for (int i = 0; i < 16; i++)
      rchk($sformatf("t4_pop_%0d", i), 8'h28, {16'(i % 4), 16'(17 * (i % 4 + 1))});
    rchk("t4_pop_empty", 8'h28, 32'h0);
    rchk("t4_level_empty", 8'h24, 32'h0);

    // Threshold interrupt: edge set, sticky clear, re-arm, set beats clear
    wr(8'h1C, 32'd4); wr(8'h04, 32'h1); wr(8'h18, 32'd3); wr(8'h20, 32'd1); wr(8'h0C, 32'hF);
    wr(8'h14, 32'h000F_0003);
    cyc(15);
    rchk("t5_ipr_set", 8'h10, 32'h1);
    chk("t5_irq", {31'b0, irq}, IRQ_ON);
    wr(8'h0C, 32'h1);
    cyc(3);
    rchk("t5_ipr_stay_clr", 8'h10, 32'h0);
    rchk("t5_pop", 8'h28, 32'h0000_0011);
    rchk("t5_level3", 8'h24, 32'd3);
    rchk("t5_ipr_below", 8'h10, 32'h0);
    wr(8'h14, 32'h0001_0003);
    cyc(10);
    rchk("t5_level4", 8'h24, 32'd4);
    rchk("t5_ipr_rearm", 8'h10, 32'h1);
    wr(8'h0C, 32'h1);
    rchk("t5_ipr_clr2", 8'h10, 32'h0);
    rchk("t5_pop2", 8'h28, 32'h0001_0022);
    wr(8'h1C, 32'd3);
    wr(8'h0C, 32'h1);
    rchk("t5_set_wins", 8'h10, 32'h1);

    // DIV=1: tick during SCAN flags MISSED; EN=0 mid-scan aborts with no more pushes
    wr(8'h1C, 32'h0); wr(8'h14, 32'h4); wr(8'h0C, 32'hF); wr(8'h04, 32'h8); wr(8'h18, 32'd1);
    wr(8'h14, 32'h000F_0001);
    cyc(4);
    wr(8'h14, 32'h000F_0000);
    cyc(10);
    rchk("t6_level", 8'h24, 32'd2);
    rchk("t6_ctrl", 8'h14, 32'h000F_0000);
    rchk("t6_ipr_missed", 8'h10, 32'h8);
    chk("t6_irq", {31'b0, irq}, IRQ_ON);
    rchk("t6_data0", 8'h28, 32'h0000_0011);
    rchk("t6_data1", 8'h28, 32'h0001_0022);

    // Asynchronous reset in the middle of a scan
    wr(8'h14, 32'h000F_0001);
    cyc(4);
    ARESET = 1'b1;
    #2;
    chk("arst_irq", {31'b0, irq}, IRQ_OFF);
    chk("arst_rvalid", {31'b0, reg_rvalid}, 32'h0);
    cyc(1);
    ARESET = 1'b0;
    rchk("arst_level", 8'h24, 32'h0);
    rchk("arst_ctrl", 8'h14, 32'h0);
    rchk("arst_ipr", 8'h10, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
